// File: rtl/pong_core.sv
// Single-clock Pong engine: game FSM, ball kinematics with progressive speed-up,
// and two paddles that are each player- or AI-driven. Every update waits for tick.
module pong_core #(
    parameter int H_RES      = 1280,
    parameter int V_RES      = 800,
    parameter int CW         = 11,
    parameter int SW         = 4,
    parameter int BALL_SIZE  = 20,
    parameter int BALL_SPEED = 10,
    parameter int SPEED_MAX  = 20,
    parameter int SPEEDUP    = 5,
    parameter int PAD_HEIGHT = 100,
    parameter int PAD_WIDTH  = 10,
    parameter int PAD_OFFS   = 35,
    parameter int PAD_SPY    = 15,
    parameter int WIN        = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          tick,
    input  logic          start,
    input  logic          pause,
    input  logic [1:0]    ai_mode,
    input  logic          l_up,
    input  logic          l_dn,
    input  logic          r_up,
    input  logic          r_dn,
    output logic [CW-1:0] ball_x,
    output logic [CW-1:0] ball_y,
    output logic [CW-1:0] padl_y,
    output logic [CW-1:0] padr_y,
    output logic [SW-1:0] score_l,
    output logic [SW-1:0] score_r,
    output logic [2:0]    state,
    output logic [1:0]    winner
);

    localparam int HW = $clog2(SPEEDUP + 1);

    typedef logic [CW:0]   wide_t;
    typedef logic [CW-1:0] coord_t;
    typedef logic [SW-1:0] score_t;
    typedef logic [HW-1:0] hits_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SERVE  = 3'd1,
        S_PLAY   = 3'd2,
        S_POINT  = 3'd3,
        S_OVER   = 3'd4,
        S_PAUSED = 3'd5
    } state_t;

    localparam wide_t BALL_X0    = wide_t'((H_RES - BALL_SIZE) / 2);
    localparam wide_t BALL_Y0    = wide_t'((V_RES - BALL_SIZE) / 2);
    localparam wide_t PAD_Y0     = wide_t'((V_RES - PAD_HEIGHT) / 2);
    localparam wide_t SERVE_XL   = wide_t'(PAD_OFFS + PAD_WIDTH);
    localparam wide_t SERVE_XR   = wide_t'(H_RES - PAD_OFFS - PAD_WIDTH - BALL_SIZE);
    localparam wide_t PAD_EDGE_R = wide_t'(H_RES - PAD_OFFS);
    localparam wide_t X_MAX      = wide_t'(H_RES - BALL_SIZE);
    localparam wide_t Y_MAX      = wide_t'(V_RES - 1 - BALL_SIZE);
    localparam wide_t Y_LIM      = wide_t'(V_RES - 1);
    localparam wide_t PAD_MAX    = wide_t'(V_RES - PAD_HEIGHT - 1);
    localparam wide_t PAD_HALF   = wide_t'(PAD_HEIGHT / 2);
    localparam wide_t BS_W       = wide_t'(BALL_SIZE);
    localparam wide_t PH_W       = wide_t'(PAD_HEIGHT);
    localparam wide_t PO_W       = wide_t'(PAD_OFFS);
    localparam wide_t PSPY_W     = wide_t'(PAD_SPY);

    state_t state_q, state_d;
    score_t score_l_q, score_l_d, score_r_q, score_r_d;
    logic [1:0] winner_q, winner_d;
    coord_t padl_y_q, padl_y_d, padr_y_q, padr_y_d;
    coord_t ball_x_q, ball_x_d, ball_y_q, ball_y_d;
    coord_t speed_q, speed_d;
    hits_t  hits_q, hits_d;
    logic   server_q, server_d;   // 0 = left serves
    logic   dx_q, dx_d;           // 1 = moving right
    logic   dy_q, dy_d;           // 1 = moving down
    logic   hit;

    wide_t bx, by, sp, pl, pr;
    logic  l_overlap, r_overlap;
    logic  l_go_up, l_go_dn, r_go_up, r_go_dn;

    function automatic coord_t pad_next(input coord_t y, input logic up, input logic dn);
        wide_t yw;
        yw = {1'b0, y};
        pad_next = y;
        if (up && !dn) begin
            pad_next = (yw < PSPY_W) ? '0 : coord_t'(yw - PSPY_W);
        end else if (dn && !up) begin
            pad_next = (yw + PSPY_W > PAD_MAX) ? coord_t'(PAD_MAX) : coord_t'(yw + PSPY_W);
        end
    endfunction

    function automatic score_t sat_inc(input score_t s);
        sat_inc = (s >= score_t'(WIN)) ? s : s + score_t'(1);
    endfunction

    assign bx = {1'b0, ball_x_q};
    assign by = {1'b0, ball_y_q};
    assign sp = {1'b0, speed_q};
    assign pl = {1'b0, padl_y_q};
    assign pr = {1'b0, padr_y_q};

    assign l_overlap = (pl <= by + BS_W) && (pl + PH_W >= by);
    assign r_overlap = (pr <= by + BS_W) && (pr + PH_W >= by);

    // AI steers the paddle centre towards the ball's vertical span.
    assign l_go_up = ai_mode[0] ? (pl + PAD_HALF > by + BS_W) : l_up;
    assign l_go_dn = ai_mode[0] ? (pl + PAD_HALF < by)        : l_dn;
    assign r_go_up = ai_mode[1] ? (pr + PAD_HALF > by + BS_W) : r_up;
    assign r_go_dn = ai_mode[1] ? (pr + PAD_HALF < by)        : r_dn;

    always_comb begin
        // NOTE: every _d starts from its held value, so no path can infer a latch.
        state_d   = state_q;
        score_l_d = score_l_q;
        score_r_d = score_r_q;
        winner_d  = winner_q;
        padl_y_d  = padl_y_q;
        padr_y_d  = padr_y_q;
        ball_x_d  = ball_x_q;
        ball_y_d  = ball_y_q;
        speed_d   = speed_q;
        hits_d    = hits_q;
        server_d  = server_q;
        dx_d      = dx_q;
        dy_d      = dy_q;
        hit       = 1'b0;

        if (tick) begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        score_l_d = '0;
                        score_r_d = '0;
                        winner_d  = 2'b00;
                        state_d   = S_SERVE;
                    end
                end
                S_SERVE: begin
                    padl_y_d = coord_t'(PAD_Y0);
                    padr_y_d = coord_t'(PAD_Y0);
                    ball_y_d = coord_t'(BALL_Y0);
                    speed_d  = coord_t'(BALL_SPEED);
                    hits_d   = '0;
                    dy_d     = 1'b1;
                    ball_x_d = server_q ? coord_t'(SERVE_XR) : coord_t'(SERVE_XL);
                    dx_d     = !server_q;
                    state_d  = S_PLAY;
                end
                S_PLAY: begin
                    if (pause) begin
                        state_d = S_PAUSED;
                    end else begin
                        padl_y_d = pad_next(padl_y_q, l_go_up, l_go_dn);
                        padr_y_d = pad_next(padr_y_q, r_go_up, r_go_dn);

                        if (!dx_q) begin
                            if (bx <= SERVE_XL && bx + BS_W >= PO_W && l_overlap) begin
                                dx_d     = 1'b1;
                                ball_x_d = coord_t'(SERVE_XL);
                                hit      = 1'b1;
                            end else if (bx < sp) begin
                                ball_x_d  = '0;
                                score_r_d = sat_inc(score_r_q);
                                server_d  = 1'b0;
                                state_d   = S_POINT;
                            end else begin
                                ball_x_d = coord_t'(bx - sp);
                            end
                        end else begin
                            if (bx >= SERVE_XR && bx <= PAD_EDGE_R && r_overlap) begin
                                dx_d     = 1'b0;
                                ball_x_d = coord_t'(SERVE_XR);
                                hit      = 1'b1;
                            end else if (bx + sp > X_MAX) begin
                                ball_x_d  = coord_t'(X_MAX);
                                score_l_d = sat_inc(score_l_q);
                                server_d  = 1'b1;
                                state_d   = S_POINT;
                            end else begin
                                ball_x_d = coord_t'(bx + sp);
                            end
                        end

                        // A speed step lands on the register; this tick still uses the old speed.
                        if (hit) begin
                            if (hits_q == hits_t'(SPEEDUP - 1)) begin
                                hits_d = '0;
                                if (speed_q < coord_t'(SPEED_MAX)) speed_d = speed_q + coord_t'(1);
                            end else begin
                                hits_d = hits_q + hits_t'(1);
                            end
                        end

                        if (dy_q) begin
                            if (by + BS_W + sp >= Y_LIM) begin
                                ball_y_d = coord_t'(Y_MAX);
                                dy_d     = 1'b0;
                            end else begin
                                ball_y_d = coord_t'(by + sp);
                            end
                        end else if (by < sp) begin
                            ball_y_d = '0;
                            dy_d     = 1'b1;
                        end else begin
                            ball_y_d = coord_t'(by - sp);
                        end
                    end
                end
                S_PAUSED: begin
                    if (!pause) state_d = S_PLAY;
                end
                S_POINT: begin
                    if (score_l_q == score_t'(WIN)) begin
                        winner_d = 2'b01;
                        state_d  = S_OVER;
                    end else if (score_r_q == score_t'(WIN)) begin
                        winner_d = 2'b10;
                        state_d  = S_OVER;
                    end else begin
                        state_d = S_SERVE;
                    end
                end
                S_OVER: begin
                    if (start) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            score_l_q <= '0;
            score_r_q <= '0;
            winner_q  <= 2'b00;
            padl_y_q  <= coord_t'(PAD_Y0);
            padr_y_q  <= coord_t'(PAD_Y0);
            ball_x_q  <= coord_t'(BALL_X0);
            ball_y_q  <= coord_t'(BALL_Y0);
            speed_q   <= coord_t'(BALL_SPEED);
            hits_q    <= '0;
            server_q  <= 1'b0;
            dx_q      <= 1'b1;
            dy_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            score_l_q <= score_l_d;
            score_r_q <= score_r_d;
            winner_q  <= winner_d;
            padl_y_q  <= padl_y_d;
            padr_y_q  <= padr_y_d;
            ball_x_q  <= ball_x_d;
            ball_y_q  <= ball_y_d;
            speed_q   <= speed_d;
            hits_q    <= hits_d;
            server_q  <= server_d;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
        end
    end

    assign ball_x  = ball_x_q;
    assign ball_y  = ball_y_q;
    assign padl_y  = padl_y_q;
    assign padr_y  = padr_y_q;
    assign score_l = score_l_q;
    assign score_r = score_r_q;
    assign state   = state_q;
    assign winner  = winner_q;

endmodule

// File: tb/tb_pong_core.sv
// Scoreboard bench for pong_core: a game-rule model predicts every cycle's outputs,
// a separate monitor compares them, plus directed scenario checks.
module tb_pong_core;

    localparam int H_RES = 1280, V_RES = 800, BS = 20, PH = 100, PW = 10, PO = 35;
    localparam int PSPY = 15, WIN = 4, SPD0 = 10, SMAX = 20, SUP = 5;
    localparam int SERVE_L = PO + PW;
    localparam int SERVE_R = H_RES - PO - PW - BS;
    localparam int X_MAX   = H_RES - BS;
    localparam int Y_MAX   = V_RES - 1 - BS;
    localparam int PAD_MAX = V_RES - PH - 1;
    localparam int PAD_C   = (V_RES - PH) / 2;

    logic clk = 1'b0, rst_n = 1'b0, tick = 1'b0, start = 1'b0, pause = 1'b0;
    logic [1:0] ai_mode = 2'b00;
    logic l_up = 1'b0, l_dn = 1'b0, r_up = 1'b0, r_dn = 1'b0;
    logic [10:0] ball_x, ball_y, padl_y, padr_y;
    logic [3:0]  score_l, score_r;
    logic [2:0]  state;
    logic [1:0]  winner;

    pong_core dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .start(start), .pause(pause),
        .ai_mode(ai_mode), .l_up(l_up), .l_dn(l_dn), .r_up(r_up), .r_dn(r_dn),
        .ball_x(ball_x), .ball_y(ball_y), .padl_y(padl_y), .padr_y(padr_y),
        .score_l(score_l), .score_r(score_r), .state(state), .winner(winner)
    );

    always #5 clk = ~clk;

    // st: 0 idle, 1 serve, 2 play, 3 point, 4 over, 5 paused; vx/vy are +1/-1
    typedef struct {
        int st, sl, sr, win, pl, pr, bx, by, spd, hits, server, vx, vy, nhit;
    } game_t;

    game_t m;
    game_t sb[$];
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic bound_fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: bound expired at %0t", name, $time);
    endtask

    function automatic game_t reset_game();
        game_t g;
        g.st = 0; g.sl = 0; g.sr = 0; g.win = 0;
        g.pl = PAD_C; g.pr = PAD_C;
        g.bx = (H_RES - BS) / 2; g.by = (V_RES - BS) / 2;
        g.spd = SPD0; g.hits = 0; g.server = 0; g.vx = 1; g.vy = 1; g.nhit = 0;
        return g;
    endfunction

    function automatic int paddle(input int y, input bit up, input bit dn);
        if (up && !dn) return (y - PSPY < 0) ? 0 : y - PSPY;
        if (dn && !up) return (y + PSPY > PAD_MAX) ? PAD_MAX : y + PSPY;
        return y;
    endfunction

    function automatic game_t step(input game_t g, input bit t, input bit s, input bit p,
                                   input bit [1:0] ai, input bit lu, input bit ld,
                                   input bit ru, input bit rd);
        game_t n;
        bit hit;
        n = g;
        hit = 0;
        if (!t) return n;
        case (g.st)
            0: if (s) begin n.sl = 0; n.sr = 0; n.win = 0; n.st = 1; end
            1: begin
                n.pl = PAD_C; n.pr = PAD_C; n.by = (V_RES - BS) / 2;
                n.spd = SPD0; n.hits = 0; n.vy = 1;
                if (g.server == 0) begin n.bx = SERVE_L; n.vx = 1; end
                else begin n.bx = SERVE_R; n.vx = -1; end
                n.st = 2;
            end
            2: begin
                if (p) begin
                    n.st = 5;
                end else begin
                    n.pl = ai[0] ? paddle(g.pl, g.pl + PH / 2 > g.by + BS, g.pl + PH / 2 < g.by)
                                 : paddle(g.pl, lu, ld);
                    n.pr = ai[1] ? paddle(g.pr, g.pr + PH / 2 > g.by + BS, g.pr + PH / 2 < g.by)
                                 : paddle(g.pr, ru, rd);
                    if (g.vx < 0) begin
                        if (g.bx <= SERVE_L && g.bx + BS >= PO && g.pl <= g.by + BS && g.pl + PH >= g.by) begin
                            n.vx = 1; n.bx = SERVE_L; hit = 1;
                        end else if (g.bx < g.spd) begin
                            n.bx = 0; n.sr = (g.sr < WIN) ? g.sr + 1 : WIN; n.server = 0; n.st = 3;
                        end else n.bx = g.bx - g.spd;
                    end else begin
                        if (g.bx >= SERVE_R && g.bx <= H_RES - PO && g.pr <= g.by + BS && g.pr + PH >= g.by) begin
                            n.vx = -1; n.bx = SERVE_R; hit = 1;
                        end else if (g.bx + g.spd > X_MAX) begin
                            n.bx = X_MAX; n.sl = (g.sl < WIN) ? g.sl + 1 : WIN; n.server = 1; n.st = 3;
                        end else n.bx = g.bx + g.spd;
                    end
                    if (hit) begin
                        n.nhit = g.nhit + 1;
                        n.hits = g.hits + 1;
                        if (n.hits == SUP) begin
                            n.hits = 0;
                            n.spd = (g.spd + 1 > SMAX) ? SMAX : g.spd + 1;
                        end
                    end
                    if (g.vy > 0) begin
                        if (g.by + BS + g.spd >= V_RES - 1) begin n.by = Y_MAX; n.vy = -1; end
                        else n.by = g.by + g.spd;
                    end else begin
                        if (g.by < g.spd) begin n.by = 0; n.vy = 1; end
                        else n.by = g.by - g.spd;
                    end
                end
            end
            3: begin
                if (g.sl == WIN) begin n.win = 1; n.st = 4; end
                else if (g.sr == WIN) begin n.win = 2; n.st = 4; end
                else n.st = 1;
            end
            4: if (s) n.st = 0;
            5: if (!p) n.st = 2;
            default: n.st = 0;
        endcase
        return n;
    endfunction

    // One clock of stimulus; the predicted post-edge outputs go to the scoreboard.
    task automatic cycle(input bit t, input bit s, input bit p, input bit [1:0] ai,
                         input bit lu, input bit ld, input bit ru, input bit rd);
        @(negedge clk);
        tick = t; start = s; pause = p; ai_mode = ai;
        l_up = lu; l_dn = ld; r_up = ru; r_dn = rd;
        m = step(m, t, s, p, ai, lu, ld, ru, rd);
        sb.push_back(m);
        @(posedge clk);
        #2;
        tick = 1'b0;
        start = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_state"},   state,   0);
        check({tag, "_score_l"}, score_l, 0);
        check({tag, "_score_r"}, score_r, 0);
        check({tag, "_winner"},  winner,  0);
        check({tag, "_padl_y"},  padl_y,  PAD_C);
        check({tag, "_padr_y"},  padr_y,  PAD_C);
        check({tag, "_ball_x"},  ball_x,  630);
        check({tag, "_ball_y"},  ball_y,  390);
    endtask

    initial begin : monitor
        game_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("sb_state",   state,   e.st);
                check("sb_score_l", score_l, e.sl);
                check("sb_score_r", score_r, e.sr);
                check("sb_winner",  winner,  e.win);
                check("sb_padl_y",  padl_y,  e.pl);
                check("sb_padr_y",  padr_y,  e.pr);
                check("sb_ball_x",  ball_x,  e.bx);
                check("sb_ball_y",  ball_y,  e.by);
            end
        end
    end

    initial begin : driver
        bit left_missed, seen11, rt, rs, rp;
        int frozen_bx, prev_spd, k;
        bit [1:0] rai;
        bit [3:0] rbtn;

        m = reset_game();
        repeat (2) @(negedge clk);
        check_reset("por");
        rst_n = 1'b1;

        // Serve sequence from reset.
        cycle(1, 1, 0, 2'b00, 0, 0, 0, 0);
        check("a_state_serve", state, 1);
        cycle(1, 0, 0, 2'b00, 0, 0, 0, 0);
        check("a_state_play", state, 2);
        check("a_serve_x", ball_x, SERVE_L);
        check("a_serve_y", ball_y, 390);
        cycle(0, 1, 1, 2'b00, 1, 0, 0, 1);
        check("a_notick_hold_x", ball_x, SERVE_L);
        cycle(1, 0, 0, 2'b00, 0, 0, 0, 0);
        check("a_play_x", ball_x, 55);
        check("a_play_y", ball_y, 400);

        // Left player idle with paddle pinned to the top until a miss.
        k = 0;
        while (m.st != 3 && k < 4000) begin
            cycle(1, 0, 0, 2'b10, 1, 0, 0, 0);
            k++;
        end
        if (m.st != 3) bound_fail("b_miss");
        else begin
            left_missed = (m.server == 0);
            check("b_point_state", state, 3);
            check("b_score_r", score_r, m.sr);
            cycle(1, 0, 0, 2'b10, 1, 0, 0, 0);
            check("b_serve_state", state, 1);
            cycle(1, 0, 0, 2'b10, 1, 0, 0, 0);
            if (left_missed) check("b_serve_left_x", ball_x, SERVE_L);
        end

        // Fresh game: right player idle at the top, left AI; play to a win.
        @(negedge clk);
        rst_n = 1'b0;
        m = reset_game();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1, 1, 0, 2'b01, 0, 0, 0, 0);
        k = 0;
        while (m.st != 4 && k < 20000) begin
            cycle(1, 0, 0, 2'b01, 0, 0, 1, 0);
            k++;
        end
        if (m.st != 4) bound_fail("c_game_over");
        else begin
            check("c_over_state", state, 4);
            check("c_winner", winner, m.win);
            if (m.win == 1) check("c_score_l_win", score_l, WIN);
            cycle(1, 1, 0, 2'b01, 0, 0, 0, 0);
            check("c_idle_state", state, 0);
            check("c_idle_keeps_score", score_l, m.sl);
            cycle(1, 1, 0, 2'b01, 0, 0, 0, 0);
            check("c_restart_state", state, 1);
            check("c_clear_score_l", score_l, 0);
            check("c_clear_score_r", score_r, 0);
            check("c_clear_winner", winner, 0);
        end

        // Pause freezes play; the resume tick shows no motion.
        if (m.st == 1) begin
            repeat (4) cycle(1, 0, 0, 2'b00, 0, 0, 0, 0);
            frozen_bx = m.bx;
            cycle(1, 0, 1, 2'b00, 0, 0, 0, 0);
            check("d_paused_state", state, 5);
            repeat (10) cycle(1, 0, 1, 2'b00, 1, 0, 1, 0);
            check("d_frozen_x", ball_x, frozen_bx);
            cycle(1, 0, 0, 2'b00, 0, 0, 0, 0);
            check("d_resume_state", state, 2);
            check("d_resume_no_motion", ball_x, frozen_bx);
            cycle(1, 0, 0, 2'b00, 0, 0, 0, 0);
            check("d_moves_again", ball_x, frozen_bx + ((m.vx > 0) ? SPD0 : -SPD0));

            // Paddle clamps and the both-pressed hold.
            repeat (30) cycle(1, 0, 0, 2'b00, 1, 0, 0, 0);
            check("e_padl_floor", padl_y, 0);
            repeat (3) cycle(1, 0, 0, 2'b00, 1, 1, 0, 0);
            check("e_padl_both_hold", padl_y, 0);
            repeat (30) cycle(1, 0, 0, 2'b00, 0, 0, 0, 1);
            check("e_padr_ceiling", padr_y, PAD_MAX);
        end

        // Asynchronous reset mid-rally, away from any clock edge.
        #1 rst_n = 1'b0;
        #1 check_reset("async");
        m = reset_game();
        @(negedge clk);
        rst_n = 1'b1;

        // Both AI: long rallies, speed-up after every fifth hit.
        seen11 = 0;
        k = 0;
        while (m.nhit < 200 && k < 40000) begin
            prev_spd = m.spd;
            cycle(1, (m.st == 0 || m.st == 4), 0, 2'b11, 0, 0, 0, 0);
            k++;
            if (!seen11 && prev_spd == SPD0 && m.spd == SPD0 + 1) begin
                seen11 = 1;
                cycle(1, 0, 0, 2'b11, 0, 0, 0, 0);
                check("f_speedup_step", ball_x, (m.vx > 0) ? SERVE_L + 11 : SERVE_R - 11);
            end
        end
        if (m.nhit < 200) bound_fail("f_200_hits");
        if (!seen11) bound_fail("f_speedup_seen");

        // Random stimulus, including start/pause pulses between ticks.
        for (int i = 0; i < 3000; i++) begin
            rt   = ($urandom_range(0, 3) != 0);
            rs   = ($urandom_range(0, 15) == 0);
            rp   = ($urandom_range(0, 19) == 0);
            rai  = 2'($urandom);
            rbtn = 4'($urandom);
            cycle(rt, rs, rp, rai, rbtn[0], rbtn[1], rbtn[2], rbtn[3]);
        end

        repeat (3) @(negedge clk);
        if (sb.size() != 0) bound_fail("scoreboard_drain");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pong_core.md
# pong_core

Parametrised single-clock Pong game engine: score/state FSM, ball kinematics with progressive speed-up, and two paddles, each independently selectable as player-driven or AI-driven at run time. It replaces the multi-clock game logic: all updates are gated by a one-cycle `tick` frame strobe on `clk`. The engine feeds the drawing and VGA stages through registered coordinate and score outputs.

## Interface
- `H_RES`, 1280: horizontal field size in pixels.
- `V_RES`, 800: vertical field size in pixels.
- `CW`, 11: coordinate width.
- `SW`, 4: score width.
- `BALL_SIZE`, 20: ball edge length.
- `BALL_SPEED`, 10: serve speed in px/tick, both axes.
- `SPEED_MAX`, 20: speed ceiling.
- `SPEEDUP`, 5: paddle hits per +1 speed step.
- `PAD_HEIGHT`, 100; `PAD_WIDTH`, 10; `PAD_OFFS`, 35: paddle geometry, mirrored left/right.
- `PAD_SPY`, 15: paddle step in px/tick.
- `WIN`, 4: winning score.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous active-low reset.
- `tick` in 1: one-cycle frame-update strobe.
- `start` in 1: leave IDLE or OVER.
- `pause` in 1: level; freeze play.
- `ai_mode` in 2: bit0 = left paddle AI, bit1 = right paddle AI; sampled on each tick.
- `l_up`, `l_dn`, `r_up`, `r_dn` in 1 each: player controls.
- `ball_x`, `ball_y` out CW: ball top-left corner.
- `padl_y`, `padr_y` out CW: paddle top edges.
- `score_l`, `score_r` out SW: scores.
- `state` out 3: IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4, PAUSED=5.
- `winner` out 2: 00 none, 01 left, 10 right.

## Operation
- All state changes occur only on a `clk` edge with `tick`=1, except reset. With `tick`=0, every register holds.
- Reset values:
  - `state`=IDLE.
  - Scores 0.
  - `winner`=00.
  - Paddles at (V_RES−PAD_HEIGHT)/2 (=350).
  - Ball at ((H_RES−BALL_SIZE)/2, (V_RES−BALL_SIZE)/2) = (630, 390).
  - speed=BALL_SPEED.
  - hit count 0.
  - server=left.
- FSM:
  - IDLE: on `start`, clear scores and `winner`, then go to SERVE.
  - SERVE:
    - Centre both paddles.
    - Set `ball_y`=390, speed=BALL_SPEED, hit count=0, dy=down.
    - Server left: `ball_x`=PAD_OFFS+PAD_WIDTH (45), dx=right.
    - Server right: `ball_x`=H_RES−PAD_OFFS−PAD_WIDTH−BALL_SIZE (1215), dx=left.
    - Go to PLAY.
  - PLAY: perform the ball and paddle updates below. A miss goes to POINT. If `pause` is high, go to PAUSED with no motion that tick.
  - PAUSED: hold everything. If `pause` is low at a tick, go to PLAY; no motion occurs on that tick.
  - POINT: if the scorer's score == WIN, set `winner` and go to OVER; else go to SERVE.
  - OVER: hold. On `start`, go to IDLE.
- Ball X update, moving left:
  - Hit: `ball_x` ≤ 45, `ball_x`+BALL_SIZE ≥ PAD_OFFS, and vertical overlap (padl_y ≤ ball_y+BALL_SIZE and padl_y+PAD_HEIGHT ≥ ball_y). Then dx=right, `ball_x`=45, hit count+1.
  - Miss: else if `ball_x` < speed, set `ball_x`=0, `score_r`+1, server=left (the conceding side serves).
  - Otherwise `ball_x` −= speed.
  - Moving right is mirrored: the hit clamps `ball_x` to 1215; the miss clamps to H_RES−BALL_SIZE, increments `score_l`, and sets server=right.
- Speed-up: when a hit brings hit count to SPEEDUP, reset hit count to 0 and set speed=min(speed+1, SPEED_MAX). The new speed applies from the next tick.
- Ball Y update:
  - Moving down: if `ball_y`+BALL_SIZE+speed ≥ V_RES−1, clamp `ball_y`=V_RES−1−BALL_SIZE and set dy=up.
  - Moving up: if `ball_y` < speed, clamp to 0 and set dy=down.
  - Otherwise step by speed.
- Paddles (PLAY only):
  - Player:
    - up only: y −= PAD_SPY, floor 0.
    - down only: y += PAD_SPY, ceiling V_RES−PAD_HEIGHT−1 (699).
    - Both or neither pressed: hold.
  - AI:
    - If y+PAD_HEIGHT/2 < `ball_y`: step down.
    - If y+PAD_HEIGHT/2 > `ball_y`+BALL_SIZE: step up.
    - Otherwise hold. Same clamps.
  - Paddle moves and ball collision checks use pre-tick paddle values.
- Arithmetic: all comparison sums are evaluated at CW+1 bits; no wrap-around. Scores never exceed WIN.

## Timing
- Outputs are registered and change on the clock edge where `tick`=1. Latency from that edge to the new values is 0 cycles.
- Ticks per phase:
  - SERVE→PLAY takes one tick.
  - A miss takes two ticks before SERVE (PLAY→POINT→SERVE).
  - A win takes PLAY→POINT→OVER.
- Asserting `rst_n` low mid-play immediately forces all reset values, independent of `clk`.
- `start` and `pause` are only sampled on ticks; pulses between ticks are ignored.

## Test plan
- Reset, then `start` at tick 1: `state` 0→1→2 over ticks 1–2; `ball_x`=45, `ball_y`=390 after SERVE; `ball_x`=55, `ball_y`=400 after the first PLAY tick.
- Both AI, no input: ball bounces; with hits logged, after the 5th paddle hit the next tick moves `ball_x` by 11. Speed never exceeds 20 over 200 hits.
- Left player idle, `padl_y` held at 0, ball aimed low: `score_r` becomes 1 on the miss tick; POINT, then SERVE from the left side.
- `score_l`=3 with WIN=4, right miss: `score_l`=4, POINT, then OVER with `winner`=01. `start` then leads to IDLE, and the next `start` clears the scores.
- `pause` high at a PLAY tick: all outputs frozen for 10 ticks. `pause` low: the resume tick shows no motion, the following tick moves.
- `l_up` held from `padl_y`=10: next tick `padl_y`=0 and it stays 0. `l_up`+`l_dn` together: hold. Asserting `rst_n` low mid-rally returns all reset values asynchronously.
